// File: rtl/smc_pkg.sv
// rtl/smc_pkg.sv - shared types and constants for the MOSFET calculator sequential front-end
package smc_pkg;

  localparam int NUM_TR = 6;
  localparam int FW     = 3;
  localparam int OW     = 10;
  localparam int MODE_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    OUT
  } state_t;

  typedef logic [2:0] beat_t;

endpackage

// File: rtl/smc_seq_loader.sv
// rtl/smc_seq_loader.sv - collects a 6-beat operand burst, presents it to the calculator, returns its result
module smc_seq_loader
  import smc_pkg::*;
#(
  parameter int NUM_TR = smc_pkg::NUM_TR,
  parameter int FW     = smc_pkg::FW,
  parameter int OW     = smc_pkg::OW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [MODE_W-1:0]   mode_in,
  input  logic [FW-1:0]       w_in,
  input  logic [FW-1:0]       vgs_in,
  input  logic [FW-1:0]       vds_in,
  output logic [MODE_W-1:0]   mode,
  output logic [FW-1:0]       W_0,
  output logic [FW-1:0]       V_GS_0,
  output logic [FW-1:0]       V_DS_0,
  output logic [FW-1:0]       W_1,
  output logic [FW-1:0]       V_GS_1,
  output logic [FW-1:0]       V_DS_1,
  output logic [FW-1:0]       W_2,
  output logic [FW-1:0]       V_GS_2,
  output logic [FW-1:0]       V_DS_2,
  output logic [FW-1:0]       W_3,
  output logic [FW-1:0]       V_GS_3,
  output logic [FW-1:0]       V_DS_3,
  output logic [FW-1:0]       W_4,
  output logic [FW-1:0]       V_GS_4,
  output logic [FW-1:0]       V_DS_4,
  output logic [FW-1:0]       W_5,
  output logic [FW-1:0]       V_GS_5,
  output logic [FW-1:0]       V_DS_5,
  input  logic [OW-1:0]       calc_out_n,
  output logic                out_valid,
  output logic [OW-1:0]       out_n,
  output logic                busy,
  output logic                err
);

  localparam beat_t LAST_BEAT = beat_t'(NUM_TR - 1);

  state_t                       r_state;
  beat_t                        r_cnt;
  logic [MODE_W-1:0]            r_mode;
  logic [NUM_TR-1:0][3*FW-1:0]  r_slot;
  logic [OW-1:0]                r_out_n;
  logic                         r_out_valid;
  logic                         r_busy;
  logic                         r_err;
  logic [3*FW-1:0]              w_triple;

  // Each slot packs {W, V_GS, V_DS}, MSB first.
  assign w_triple = {w_in, vgs_in, vds_in};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mode      <= '0;
      r_slot      <= '0;
      r_out_n     <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_n     <= '0;
      r_err       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mode    <= mode_in;
            r_slot[0] <= w_triple;
            r_cnt     <= beat_t'(1);
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            r_slot[r_cnt] <= w_triple;
            if (r_cnt == LAST_BEAT) begin
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= CALC;
            end else begin
              r_cnt <= beat_t'(r_cnt + beat_t'(1));
            end
          end else begin
            // Gap in the burst: drop it, keep whatever slots were already written.
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_out_n     <= calc_out_n;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mode      = r_mode;
  assign out_n     = r_out_n;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign err       = r_err;

  assign {W_0, V_GS_0, V_DS_0} = r_slot[0];
  assign {W_1, V_GS_1, V_DS_1} = r_slot[1];
  assign {W_2, V_GS_2, V_DS_2} = r_slot[2];
  assign {W_3, V_GS_3, V_DS_3} = r_slot[3];
  assign {W_4, V_GS_4, V_DS_4} = r_slot[4];
  assign {W_5, V_GS_5, V_DS_5} = r_slot[5];

endmodule

// File: tb/tb_smc_seq_loader.sv
// tb/tb_smc_seq_loader.sv - table-driven and directed self-checking bench for smc_seq_loader
module tb_smc_seq_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] mode_in;
  logic [2:0] w_in, vgs_in, vds_in;
  logic [1:0] mode;
  logic [2:0] W_0, V_GS_0, V_DS_0, W_1, V_GS_1, V_DS_1, W_2, V_GS_2, V_DS_2;
  logic [2:0] W_3, V_GS_3, V_DS_3, W_4, V_GS_4, V_DS_4, W_5, V_GS_5, V_DS_5;
  logic [9:0] calc_out_n;
  logic       out_valid;
  logic [9:0] out_n;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  smc_seq_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode_in(mode_in),
    .w_in(w_in), .vgs_in(vgs_in), .vds_in(vds_in), .mode(mode),
    .W_0(W_0), .V_GS_0(V_GS_0), .V_DS_0(V_DS_0),
    .W_1(W_1), .V_GS_1(V_GS_1), .V_DS_1(V_DS_1),
    .W_2(W_2), .V_GS_2(V_GS_2), .V_DS_2(V_DS_2),
    .W_3(W_3), .V_GS_3(V_GS_3), .V_DS_3(V_DS_3),
    .W_4(W_4), .V_GS_4(V_GS_4), .V_DS_4(V_DS_4),
    .W_5(W_5), .V_GS_5(V_GS_5), .V_DS_5(V_DS_5),
    .calc_out_n(calc_out_n), .out_valid(out_valid), .out_n(out_n),
    .busy(busy), .err(err)
  );

  logic [8:0] s_act [6];
  assign s_act[0] = {W_0, V_GS_0, V_DS_0};
  assign s_act[1] = {W_1, V_GS_1, V_DS_1};
  assign s_act[2] = {W_2, V_GS_2, V_DS_2};
  assign s_act[3] = {W_3, V_GS_3, V_DS_3};
  assign s_act[4] = {W_4, V_GS_4, V_DS_4};
  assign s_act[5] = {W_5, V_GS_5, V_DS_5};

  // Row i: inputs during cycle t+i, expected outputs in cycle t+i+1.
  typedef struct {
    logic       iv;
    logic [1:0] md;
    logic [2:0] w, g, d;
    logic [9:0] calc;
    logic       e_ov;
    logic [9:0] e_on;
    logic       e_busy;
    logic       e_err;
    logic [1:0] e_mode;
    logic [8:0] e_s3;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic iv, logic [1:0] md, logic [2:0] w, logic [2:0] g,
                              logic [2:0] d, logic [9:0] calc, logic e_ov, logic [9:0] e_on,
                              logic e_busy, logic [1:0] e_mode, logic [8:0] e_s3);
    vec_t v;
    v.iv = iv; v.md = md; v.w = w; v.g = g; v.d = d; v.calc = calc;
    v.e_ov = e_ov; v.e_on = e_on; v.e_busy = e_busy; v.e_err = 1'b0;
    v.e_mode = e_mode; v.e_s3 = e_s3;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [1:0] md, input logic [2:0] w,
                       input logic [2:0] g, input logic [2:0] d, input logic [9:0] c);
    in_valid = iv; mode_in = md; w_in = w; vgs_in = g; vds_in = d; calc_out_n = c;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mode"}, int'(mode), 0);
    chk({tag, "_out_n"}, int'(out_n), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_err"}, int'(err), 0);
    for (int k = 0; k < 6; k++) chk($sformatf("%s_slot%0d", tag, k), int'(s_act[k]), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 10'd99);
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Nominal burst with mode_in flipping to 3 on beat 2, then a back-to-back burst at t+8.
    tbl[0]  = mk(1, 2, 1, 1, 1, 99,  0, 0,   0, 2, 9'd0);
    tbl[1]  = mk(1, 2, 2, 2, 2, 99,  0, 0,   0, 2, 9'd0);
    tbl[2]  = mk(1, 3, 3, 3, 3, 99,  0, 0,   0, 2, 9'd0);
    tbl[3]  = mk(1, 3, 4, 4, 4, 99,  0, 0,   0, 2, 9'd292);
    tbl[4]  = mk(1, 3, 5, 5, 5, 99,  0, 0,   0, 2, 9'd292);
    tbl[5]  = mk(1, 3, 6, 6, 6, 99,  0, 0,   1, 2, 9'd292);
    tbl[6]  = mk(0, 0, 0, 0, 0, 517, 1, 517, 1, 2, 9'd292);
    tbl[7]  = mk(0, 0, 0, 0, 0, 99,  0, 0,   0, 2, 9'd292);
    tbl[8]  = mk(1, 1, 0, 7, 1, 99,  0, 0,   0, 1, 9'd292);
    tbl[9]  = mk(1, 1, 1, 6, 1, 99,  0, 0,   0, 1, 9'd292);
    tbl[10] = mk(1, 1, 2, 5, 1, 99,  0, 0,   0, 1, 9'd292);
    tbl[11] = mk(1, 1, 3, 4, 1, 99,  0, 0,   0, 1, 9'd225);
    tbl[12] = mk(1, 1, 4, 3, 1, 99,  0, 0,   0, 1, 9'd225);
    tbl[13] = mk(1, 1, 5, 2, 1, 99,  0, 0,   1, 1, 9'd225);
    tbl[14] = mk(0, 0, 0, 0, 0, 682, 1, 682, 1, 1, 9'd225);
    tbl[15] = mk(0, 0, 0, 0, 0, 99,  0, 0,   0, 1, 9'd225);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].iv, tbl[i].md, tbl[i].w, tbl[i].g, tbl[i].d, tbl[i].calc);
      tick();
      chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_out_n", i), int'(out_n), int'(tbl[i].e_on));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].e_err));
      chk($sformatf("tbl%0d_mode", i), int'(mode), int'(tbl[i].e_mode));
      chk($sformatf("tbl%0d_slot3", i), int'(s_act[3]), int'(tbl[i].e_s3));
    end
    for (int k = 0; k < 6; k++)
      chk($sformatf("b2b_slot%0d", k), int'(s_act[k]), (k << 6) | ((7 - k) << 3) | 1);

    // Short burst: 4 beats of (6,6,6) then a gap; err only in t+5.
    for (int c = 0; c < 7; c++) begin
      drive(c < 4, 2'd3, 3'd6, 3'd6, 3'd6, 10'd517);
      tick();
      chk($sformatf("short_err_t%0d", c + 1), int'(err), (c + 1 == 5) ? 1 : 0);
      chk($sformatf("short_ov_t%0d", c + 1), int'(out_valid), 0);
    end
    chk("short_busy", int'(busy), 0);
    chk("short_mode", int'(mode), 3);
    for (int k = 0; k < 6; k++)
      chk($sformatf("short_slot%0d", k), int'(s_act[k]),
          (k < 4) ? 438 : ((k << 6) | ((7 - k) << 3) | 1));

    // Over-long burst: beats 6 and 7 carry (7,7,7) and must be ignored.
    for (int c = 0; c < 10; c++) begin
      if (c < 6) drive(1'b1, 2'd0, 3'(c), 3'(c), 3'd2, (c == 6) ? 10'd300 : 10'd99);
      else       drive(c < 8, 2'd0, 3'd7, 3'd7, 3'd7, (c == 6) ? 10'd300 : 10'd99);
      tick();
      chk($sformatf("long_ov_t%0d", c + 1), int'(out_valid), (c + 1 == 7) ? 1 : 0);
      chk($sformatf("long_out_n_t%0d", c + 1), int'(out_n), (c + 1 == 7) ? 300 : 0);
      chk($sformatf("long_err_t%0d", c + 1), int'(err), 0);
    end
    for (int k = 0; k < 6; k++)
      chk($sformatf("long_slot%0d", k), int'(s_act[k]), k * 72 + 2);

    // Mid-burst reset at t+3, then a full burst from t+5.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 2'd3, 3'd5, 3'd5, 3'd5, 10'd99);
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk_all_zero("midrst");
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 10'd99);
    tick();
    for (int c = 5; c < 13; c++) begin
      drive(c < 11, 2'd1, 3'd1, 3'd2, 3'd3, (c == 11) ? 10'd555 : 10'd99);
      tick();
      chk($sformatf("midrst_ov_t%0d", c + 1), int'(out_valid), (c + 1 == 12) ? 1 : 0);
      if (c + 1 == 12) chk("midrst_out_n", int'(out_n), 555);
    end
    chk("midrst_mode", int'(mode), 1);
    for (int k = 0; k < 6; k++) chk($sformatf("midrst_slot%0d", k), int'(s_act[k]), 83);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
